// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: sequencer states and status codes shared by run_ctrl and its bench.
package run_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CORE_RST, CHECK, REQ, WAIT, DRAIN, REPORT} state_t;
  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_TIMEOUT    = 2'd1;
  localparam logic [1:0] ST_DONE_STUCK = 2'd2;
endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host, core and data-memory signals of run_ctrl; master is the controller side.
interface run_ctrl_if #(parameter int AW = 8, parameter int CW = 16) ();
  logic          start;
  logic [AW-1:0] res_base;
  logic [AW-1:0] res_len;
  logic          busy;
  logic          core_rst;
  logic          req;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          stat_valid;
  logic [1:0]    stat_code;
  logic [CW-1:0] run_cycles;
  logic [7:0]    checksum;
  modport master (
    input  start, res_base, res_len, done, mem_rd_data,
    output busy, core_rst, req, mem_rd_en, mem_rd_addr, stat_valid, stat_code, run_cycles, checksum
  );
  modport slave (
    output start, res_base, res_len, done, mem_rd_data,
    input  busy, core_rst, req, mem_rd_en, mem_rd_addr, stat_valid, stat_code, run_cycles, checksum
  );
endinterface

// File: rtl/run_ctrl_drain.sv
// run_ctrl_drain: reads len bytes from base (address wraps) and sums them; data lands one cycle after each read.
module run_ctrl_drain import run_ctrl_pkg::*; #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          go,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          fin,
  output logic [7:0]    sum
);
  logic          act;
  logic          pend;
  logic [AW-1:0] left;
  // finishes on the cycle after the last read, when its byte is being accumulated
  assign fin = act && !rd_en;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act     <= 1'b0;
      pend    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      left    <= '0;
      sum     <= '0;
    end else begin
      pend <= rd_en;
      sum  <= clr ? '0 : pend ? sum + rd_data : sum;
      if (go) begin
        act     <= 1'b1;
        rd_en   <= len != '0;
        rd_addr <= base;
        left    <= len;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        left    <= left - 1'b1;
        rd_en   <= left != AW'(1);
      end else if (fin) begin
        act <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: resets the core, pulses req, times done, then checksums the result window.
// Define RUN_CTRL_TIMEOUT_EN to abort a WAIT that reaches TIMEOUT cycles.
module run_ctrl import run_ctrl_pkg::*; #(
  parameter int RST_CYC = 4,
  parameter int AW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.master bus
);
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [RW-1:0] R_LAST = RW'(RST_CYC - 1);
  state_t        state;
  logic [RW-1:0] cnt;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          fin;
  logic          to_hit;
  assign to_hit = TO_EN && bus.run_cycles == CW'(TIMEOUT);
  run_ctrl_drain #(.AW(AW)) u_drain (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE && bus.start),
    .go      (state == WAIT && bus.done),
    .base    (base),
    .len     (len),
    .rd_en   (bus.mem_rd_en),
    .rd_addr (bus.mem_rd_addr),
    .rd_data (bus.mem_rd_data),
    .fin     (fin),
    .sum     (bus.checksum)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      base           <= '0;
      len            <= '0;
      bus.busy       <= 1'b0;
      bus.core_rst   <= 1'b0;
      bus.req        <= 1'b0;
      bus.stat_valid <= 1'b0;
      bus.stat_code  <= ST_OK;
      bus.run_cycles <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          base           <= bus.res_base;
          len            <= bus.res_len;
          cnt            <= '0;
          bus.run_cycles <= '0;
          bus.stat_code  <= ST_OK;
          bus.busy       <= 1'b1;
          bus.core_rst   <= 1'b1;
          state          <= CORE_RST;
        end
        CORE_RST: if (cnt == R_LAST) begin
          bus.core_rst <= 1'b0;
          state        <= CHECK;
        end else begin
          cnt <= cnt + 1'b1;
        end
        CHECK: if (bus.done) begin
          bus.stat_code  <= ST_DONE_STUCK;
          bus.stat_valid <= 1'b1;
          state          <= REPORT;
        end else begin
          bus.req <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          bus.req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (bus.done) begin
          state <= DRAIN;
        end else if (to_hit) begin
          // watchdog: knock the hung core back into reset for the report cycle
          bus.stat_code  <= ST_TIMEOUT;
          bus.core_rst   <= 1'b1;
          bus.stat_valid <= 1'b1;
          state          <= REPORT;
        end else begin
          bus.run_cycles <= &bus.run_cycles ? bus.run_cycles : bus.run_cycles + 1'b1;
        end
        DRAIN: if (fin) begin
          bus.stat_valid <= 1'b1;
          state          <= REPORT;
        end
        REPORT: begin
          bus.stat_valid <= 1'b0;
          bus.busy       <= 1'b0;
          bus.core_rst   <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed runs of run_ctrl against a scoreboard of expected status and read addresses.
module tb_run_ctrl;
  import run_ctrl_pkg::*;
  localparam int AW = 8;
  localparam int CW = 16;
  typedef struct {int code; int cyc; int sum; int nrd; int nreq; int nrst;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  run_ctrl_if #(.AW(AW), .CW(CW)) bus ();
  run_ctrl #(.RST_CYC(4), .AW(AW), .CW(CW), .TIMEOUT(20)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] mem [256];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  int n_rst = 0, n_req = 0, n_rd = 0, n_sv = 0;
  logic [7:0] rd_log [$];
  always @(negedge clk) begin
    if (bus.core_rst) n_rst++;
    if (bus.req) n_req++;
    if (bus.stat_valid) n_sv++;
    if (bus.mem_rd_en) begin
      n_rd++;
      rd_log.push_back(bus.mem_rd_addr);
    end
  end
  exp_t sb [$];
  logic [7:0] ea [$];
  int n_cmp = 0, n_bad = 0;
  int rst0, req0, rd0, sv0, rd_idx, lat;
  bit ok;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mark();
    rst0 = n_rst; req0 = n_req; rd0 = n_rd; sv0 = n_sv; rd_idx = rd_log.size();
  endtask
  task automatic push_addrs(input logic [7:0] b, input int l);
    for (int i = 0; i < l; i++) ea.push_back(b + 8'(i));
  endtask
  task automatic go(input logic [7:0] b, input logic [7:0] l);
    @(negedge clk);
    bus.res_base = b;
    bus.res_len  = l;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.req) seen = 1'b1;
      else @(negedge clk);
    end
  endtask
  task automatic finish_run(input string tag, output int cycles);
    bit seen;
    exp_t e;
    logic [63:0] a;
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (bus.stat_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    e = sb.pop_front();
    chk({tag, "_stat_valid_seen"}, 64'(seen), 1);
    if (seen) begin
      chk({tag, "_stat_code"}, bus.stat_code, e.code);
      chk({tag, "_run_cycles"}, bus.run_cycles, e.cyc);
      chk({tag, "_checksum"}, bus.checksum, e.sum);
      chk({tag, "_busy_in_report"}, bus.busy, 1);
      @(negedge clk);
      chk({tag, "_after_report"}, {bus.busy, bus.stat_valid, bus.stat_code, bus.checksum},
          {1'b0, 1'b0, 2'(e.code), 8'(e.sum)});
      chk({tag, "_core_rst_cycles"}, n_rst - rst0, e.nrst);
      chk({tag, "_req_pulses"}, n_req - req0, e.nreq);
      chk({tag, "_stat_valid_pulses"}, n_sv - sv0, 1);
      chk({tag, "_reads"}, n_rd - rd0, e.nrd);
      for (int i = 0; i < e.nrd; i++) begin
        a = (rd_idx + i < rd_log.size()) ? 64'(rd_log[rd_idx + i]) : 64'h1ff;
        chk({tag, "_rd_addr"}, a, ea.pop_front());
      end
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.done = 1'b0; bus.res_base = '0; bus.res_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h03; mem[8'h43] = 8'h04;
    mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h80; mem[8'h00] = 8'h05;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.core_rst, bus.req, bus.mem_rd_en, bus.stat_valid, bus.stat_code,
        bus.mem_rd_addr, bus.run_cycles, bus.checksum}, 0);
    reset = 1'b1;
    // done first visible after 10 full WAIT cycles -> run_cycles 10
    mark(); sb.push_back('{int'(ST_OK), 10, 8'h0A, 4, 1, 4}); push_addrs(8'h40, 4);
    go(8'h40, 8'd4);
    wait_req(ok); chk("t1_req_seen", 64'(ok), 1);
    repeat (11) @(negedge clk);
    bus.done = 1'b1;
    finish_run("t1", lat);
    bus.done = 1'b0;
    // wrap-around window, done on the very first WAIT cycle -> run_cycles 0
    mark(); sb.push_back('{int'(ST_OK), 0, 8'h05, 3, 1, 4}); push_addrs(8'hFE, 3);
    go(8'hFE, 8'd3);
    wait_req(ok); chk("t2_req_seen", 64'(ok), 1);
    @(negedge clk);
    bus.done = 1'b1;
    finish_run("t2", lat);
    // done already high before the run starts
    mark(); sb.push_back('{int'(ST_DONE_STUCK), 0, 0, 0, 0, 4});
    go(8'h40, 8'd4);
    finish_run("t3", lat);
    chk("t3_report_latency", lat, 5);
    bus.done = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
    mark(); sb.push_back('{int'(ST_TIMEOUT), 20, 0, 0, 1, 5});
    go(8'h40, 8'd4);
    wait_req(ok); chk("t4_req_seen", 64'(ok), 1);
    finish_run("t4", lat);
    go(8'h10, 8'd2);
    wait_req(ok); chk("t5_req_seen", 64'(ok), 1);
    repeat (3) @(negedge clk);
`else
    mark();
    go(8'h10, 8'd2);
    wait_req(ok); chk("t4_req_seen", 64'(ok), 1);
    repeat (1000) @(negedge clk);
    chk("t4_hung_busy", bus.busy, 1);
    chk("t4_hung_no_stat", n_sv - sv0, 0);
`endif
    mark();
    reset = 1'b0;
    #1;
    chk("t5_abort_outputs", {bus.busy, bus.core_rst, bus.req, bus.mem_rd_en, bus.stat_valid, bus.stat_code,
        bus.mem_rd_addr, bus.run_cycles, bus.checksum}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_stat_after_abort", n_sv - sv0, 0);
    mark(); sb.push_back('{int'(ST_OK), 3, 8'h0A, 4, 1, 4}); push_addrs(8'h40, 4);
    go(8'h40, 8'd4);
    wait_req(ok); chk("t5_rerun_req_seen", 64'(ok), 1);
    repeat (4) @(negedge clk);
    bus.done = 1'b1;
    finish_run("t5", lat);
    bus.done = 1'b0;
    // empty window with start held high through REPORT: re-run only starts from IDLE
    mark();
    sb.push_back('{int'(ST_OK), 1, 0, 0, 1, 4});
    sb.push_back('{int'(ST_OK), 0, 0, 0, 1, 4});
    @(negedge clk);
    bus.res_base = 8'h20; bus.res_len = 8'd0; bus.start = 1'b1;
    @(negedge clk);
    wait_req(ok); chk("t6_req_seen", 64'(ok), 1);
    repeat (2) @(negedge clk);
    bus.done = 1'b1;
    finish_run("t6", lat);
    bus.done = 1'b0;
    mark();
    @(negedge clk);
    chk("t6_restart_from_idle", {bus.busy, bus.core_rst}, 2'b11);
    bus.start = 1'b0;
    wait_req(ok); chk("t6b_req_seen", 64'(ok), 1);
    @(negedge clk);
    bus.done = 1'b1;
    finish_run("t6b", lat);
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
